sub12_digit_serial: RTL and testbench
=====================================

// Module: sub12_digit_serial
// PURPOSE
//  Sequential 12-bit unsigned subtractor: diff = a - b - bin, bout = borrow out.
//  Processes one 4-bit digit per cycle, LSB first, through one 4-bit carry-look-ahead slice.
//  Sits beside the 12-bit CLA adder in the datapath and provides its subtract direction.
//  Valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  WIDTH  12  operand/result width; must be an integer multiple of DIGIT
//  DIGIT   4  bits processed per cycle (width of the CLA slice)
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand set a/b/bin is valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend, unsigned
//  b          in   WIDTH  subtrahend, unsigned
//  bin        in   1      borrow in
//  out_valid  out  1      diff/bout hold a completed result
//  out_ready  in   1      consumer accepts the result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      1 iff a < b + bin (unsigned)
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, digit index=0, internal regs=0.
//  - Reset has priority over every other event, including mid-CALC and in DONE: the operation
//    in flight is discarded and no result is presented.
//  - Arithmetic: a + ~b + carry, with carry_in = ~bin. Per digit i: slice(a[i], ~b[i], c) -> s, c'.
//    diff digit i = s. After the last digit, bout = ~c'. Carry is registered between digits.
//  - FSM:
//      IDLE -> CALC on in_valid & in_ready. Latch a, ~b, carry = ~bin; idx=0.
//      CALC: one digit per cycle. idx increments each cycle. After digit NDIG-1 (NDIG=WIDTH/DIGIT=3),
//            write diff/bout and go to DONE.
//      DONE: out_valid=1. On out_ready go to IDLE and clear out_valid.
//  - Latency: operands captured at edge E0. Digits resolve at E1..E3. out_valid is high from E3.
//    With out_ready held high, in_ready returns at E4, so throughput is 1 result per 5 cycles.
//  - in_ready=0 in CALC and DONE. in_valid outside IDLE is ignored; operands are not re-sampled.
//  - diff/bout are stable while out_valid=1 and keep their last value after hand-off,
//    until the next completion or reset.
//  - Backpressure: DONE holds indefinitely while out_ready=0. out_ready outside DONE has no effect.
//  - Wrap: 0 - 0 - 1 gives diff=all ones, bout=1. Full-scale 4095 - 0 - 0 gives 4095, bout=0.
// STRUCTURE
//  - Shared package: WIDTH, DIGIT, NDIG=WIDTH/DIGIT, the state enum {IDLE, CALC, DONE},
//    and the index width $clog2(NDIG).
//  - One sub-module: cla4_slice. Combinational DIGIT-bit CLA with ports a, b, cin -> s, cout.
//    It uses generate/propagate look-ahead, not ripple.
//  - Top contains the FSM, the operand shift registers, the carry flop and the result register.
// TESTING
//  1. a=0, b=0, bin=0 -> diff=0, bout=0. out_valid rises exactly 3 edges after capture.
//  2. a=15, b=1795, bin=0 -> diff=2316, bout=1. Swap operands: a=1795, b=15 -> diff=1780, bout=0.
//  3. a=12, b=14, bin=1 -> diff=4093, bout=1. a=0, b=0, bin=1 -> diff=4095, bout=1.
//  4. a=3311, b=11, bin=1 -> diff=3299, bout=0. a=4095, b=4095, bin=0 -> diff=0, bout=0.
//  5. Hold out_ready=0 for 5 cycles in DONE: out_valid, diff and bout stay constant, and in_ready
//     stays 0. Drive in_valid with new operands meanwhile: they are ignored.
//     Release out_ready: IDLE follows next cycle.
//  6. Assert rst for 1 cycle at the 2nd CALC cycle: all outputs return to reset values and out_valid
//     never rises. The next operation completes correctly.
//  Plus: 1000 random a/b/bin triples with random out_ready stalls, checked against a behavioural
//  a - b - bin model; the bench flags any handshake protocol violation.

Source files
------------

// File: rtl/sub12_digit_serial_pkg.sv
// Shared widths and state encoding for the digit-serial 12-bit subtractor.
package sub12_digit_serial_pkg;

    localparam int unsigned SUB_WIDTH = 12;
    localparam int unsigned SUB_DIGIT = 4;
    localparam int unsigned SUB_NDIG  = SUB_WIDTH / SUB_DIGIT;
    localparam int unsigned SUB_IDX_W = (SUB_NDIG > 1) ? $clog2(SUB_NDIG) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla4_slice.sv
// Combinational DIGIT-bit carry-look-ahead adder slice (generate/propagate form).
module cla4_slice
    import sub12_digit_serial_pkg::*;
#(
    parameter int unsigned DIGIT = SUB_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT-1:0] w_g;
    logic [DIGIT-1:0] w_p;
    logic [DIGIT:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum of products over g/p and cin, no ripple chain.
    always_comb begin
        logic t_acc;
        logic t_term;
        t_acc  = 1'b0;
        t_term = 1'b0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            t_term = cin;
            for (int j = 0; j <= i; j++) begin
                t_term = t_term & w_p[j];
            end
            t_acc = t_term;
            for (int k = 0; k <= i; k++) begin
                t_term = w_g[k];
                for (int j = k + 1; j <= i; j++) begin
                    t_term = t_term & w_p[j];
                end
                t_acc = t_acc | t_term;
            end
            w_c[i+1] = t_acc;
        end
    end

    assign s    = w_p ^ w_c[DIGIT-1:0];
    assign cout = w_c[DIGIT];

endmodule

// File: rtl/sub12_digit_serial.sv
// Sequential unsigned subtractor a - b - bin, one DIGIT-bit slice per cycle, LSB first,
// with valid/ready handshakes on operand and result sides.
module sub12_digit_serial
    import sub12_digit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH,
    parameter int unsigned DIGIT = SUB_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_nb_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_carry_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_bout_nxt;
    logic             w_out_valid_nxt;
    logic             w_in_ready_nxt;

    logic [DIGIT-1:0] w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_shift;

    // Subtraction as a + ~b + ~bin; the low digit of the shifted operands feeds the slice.
    cla4_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_nb[DIGIT-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_acc_shift = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_nb_nxt        = r_nb;
        w_acc_nxt       = r_acc;
        w_carry_nxt     = r_carry;
        w_idx_nxt       = r_idx;
        w_diff_nxt      = r_diff;
        w_bout_nxt      = r_bout;
        w_out_valid_nxt = r_out_valid;
        w_in_ready_nxt  = r_in_ready;

        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_a_nxt        = a;
                    w_nb_nxt       = ~b;
                    w_carry_nxt    = ~bin;
                    w_acc_nxt      = '0;
                    w_idx_nxt      = '0;
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = ST_CALC;
                end
            end
            ST_CALC: begin
                w_a_nxt     = r_a >> DIGIT;
                w_nb_nxt    = r_nb >> DIGIT;
                w_acc_nxt   = w_acc_shift;
                w_carry_nxt = w_cout;
                w_idx_nxt   = r_idx + IDX_W'(1);
                if (r_idx == LAST_IDX) begin
                    w_diff_nxt      = w_acc_shift;
                    w_bout_nxt      = ~w_cout;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_nb        <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_nb        <= w_nb_nxt;
            r_acc       <= w_acc_nxt;
            r_carry     <= w_carry_nxt;
            r_idx       <= w_idx_nxt;
            r_diff      <= w_diff_nxt;
            r_bout      <= w_bout_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_sub12_digit_serial.sv
// Self-checking bench for sub12_digit_serial: directed table, corner sequences, random ops.
module tb_sub12_digit_serial;
    import sub12_digit_serial_pkg::*;

    localparam int unsigned W = SUB_WIDTH;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    int n_vec = 0;
    int n_err = 0;

    sub12_digit_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plain integer arithmetic reference: difference mod 2^W and sign of the true result.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
        int d;
        d = int'(ra) - int'(rb) - int'(rbin);
        return {d < 0, W'(d & ((1 << W) - 1))};
    endfunction

    // One full handshake: present operands, measure latency, hold out_ready low for
    // 'stall' cycles (optionally poking in_valid), then release and check return to idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input int stall, input bit poke, input logic [W-1:0] ediff,
                          input logic ebout, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "/in_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        bin = tbin;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        bin = 1'($urandom);
        check({tag, "/in_ready_after_capture"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (in_ready && out_valid) check({tag, "/ready_valid_overlap"}, 32'd1, 32'd0);
        end
        check({tag, "/latency"}, 32'(n), 32'd3);
        check({tag, "/diff"}, 32'(diff), 32'(ediff));
        check({tag, "/bout"}, 32'(bout), 32'(ebout));
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = $urandom;
                b = $urandom;
                bin = 1'($urandom);
            end
            @(negedge clk);
            check({tag, "/stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/stall_diff"}, 32'(diff), 32'(ediff));
            check({tag, "/stall_bout"}, 32'(bout), 32'(ebout));
            check({tag, "/stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "/diff_kept"}, 32'(diff), 32'(ediff));
    endtask

    initial begin
        vec_t       vecs[6];
        logic [W:0] r;
        logic [W-1:0] ra, rb;
        logic       rbin;

        vecs[0] = '{a: 12'd0,    b: 12'd0,    bin: 1'b0, diff: 12'd0,    bout: 1'b0};
        vecs[1] = '{a: 12'd15,   b: 12'd1795, bin: 1'b0, diff: 12'd2316, bout: 1'b1};
        vecs[2] = '{a: 12'd1795, b: 12'd15,   bin: 1'b0, diff: 12'd1780, bout: 1'b0};
        vecs[3] = '{a: 12'd12,   b: 12'd14,   bin: 1'b1, diff: 12'd4093, bout: 1'b1};
        vecs[4] = '{a: 12'd0,    b: 12'd0,    bin: 1'b1, diff: 12'd4095, bout: 1'b1};
        vecs[5] = '{a: 12'd3311, b: 12'd11,   bin: 1'b1, diff: 12'd3299, bout: 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/diff", 32'(diff), 32'd0);
        check("reset/bout", 32'(bout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, 1'b0, vecs[i].diff, vecs[i].bout,
                   $sformatf("table%0d", i));
        end
        run_op(12'd4095, 12'd4095, 1'b0, 0, 1'b0, 12'd0, 1'b0, "full_equal");
        run_op(12'd4095, 12'd0, 1'b0, 0, 1'b0, 12'd4095, 1'b0, "full_scale");

        // Backpressure with new operands offered while the result waits.
        run_op(12'd1795, 12'd15, 1'b0, 5, 1'b1, 12'd1780, 1'b0, "backpressure");

        // Reset during the second CALC cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a = 12'd100;
        b = 12'd7;
        bin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset/in_ready", 32'(in_ready), 32'd1);
        check("midreset/out_valid", 32'(out_valid), 32'd0);
        check("midreset/diff", 32'(diff), 32'd0);
        check("midreset/bout", 32'(bout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midreset/no_valid", 32'(out_valid), 32'd0);
        end
        run_op(12'd12, 12'd14, 1'b1, 1, 1'b0, 12'd4093, 1'b1, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            r = ref_sub(ra, rb, rbin);
            run_op(ra, rb, rbin, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   r[W-1:0], r[W], $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
